// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    // Write-entry data width; must equal the top-level bit_size.
    localparam int unsigned DATA_W   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of write-back entries, no fall-through.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t wdata,
    input  logic      pop,
    output wb_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load paths; exports a pending-write map.
// Define WB_ARB_FIXED_PRIO_EN for fixed LD-first priority instead of round-robin.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned bit_size = 32,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [bit_size-1:0] alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [bit_size-1:0] ld_data,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   Write_addr,
    output logic [bit_size-1:0] Write_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                idle
);

    // Worst case per register: both FIFOs full of it plus one in the output register.
    localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);

    wb_entry_t alu_in, ld_in, alu_head, ld_head, grant_entry;
    logic      alu_full, alu_empty, ld_full, ld_empty;
    logic      alu_push, ld_push, alu_pop, ld_pop;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    assign alu_ready = rst && !alu_full;
    assign ld_ready  = rst && !ld_full;
    assign alu_push  = alu_valid && alu_ready;
    assign ld_push   = ld_valid && ld_ready;

    assign alu_in.addr = alu_addr;
    assign alu_in.data = alu_data;
    assign ld_in.addr  = ld_addr;
    assign ld_in.data  = ld_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .wdata (alu_in),
        .pop   (alu_pop),
        .rdata (alu_head),
        .full  (alu_full),
        .empty (alu_empty)
    );

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_push),
        .wdata (ld_in),
        .pop   (ld_pop),
        .rdata (ld_head),
        .full  (ld_full),
        .empty (ld_empty)
    );

`ifndef WB_ARB_FIXED_PRIO_EN
    req_e last_q;

    // Reset to ALU so the first contended grant goes to LD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= REQ_ALU;
        end else if (alu_pop) begin
            last_q <= REQ_ALU;
        end else if (ld_pop) begin
            last_q <= REQ_LD;
        end
    end
`endif

    always_comb begin
        alu_pop = 1'b0;
        ld_pop  = 1'b0;
        if (!alu_empty && !ld_empty) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            ld_pop = 1'b1;
`else
            if (last_q == REQ_LD) begin
                alu_pop = 1'b1;
            end else begin
                ld_pop = 1'b1;
            end
`endif
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!ld_empty) begin
            ld_pop = 1'b1;
        end
    end

    assign grant_entry = ld_pop ? ld_head : alu_head;

    // Address-0 entries are consumed without a strobe; address/data hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            Write_addr <= '0;
            Write_data <= '0;
        end else begin
            RegWrite <= 1'b0;
            if ((alu_pop || ld_pop) && (grant_entry.addr != '0)) begin
                RegWrite   <= 1'b1;
                Write_addr <= grant_entry.addr;
                Write_data <= grant_entry.data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i != 0) begin
                if (alu_push && (alu_addr == ADDR_W'(i))) begin
                    cnt_d[i] = cnt_d[i] + CNT_W'(1);
                end
                if (ld_push && (ld_addr == ADDR_W'(i))) begin
                    cnt_d[i] = cnt_d[i] + CNT_W'(1);
                end
                if (RegWrite && (Write_addr == ADDR_W'(i))) begin
                    cnt_d[i] = cnt_d[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    assign idle = alu_empty && ld_empty && !RegWrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: per-requester expected queues checked on each RegWrite.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        RegWrite;
    logic [4:0]  Write_addr;
    logic [31:0] Write_data;
    logic [31:0] pending;
    logic        idle;

    regfile_wb_arbiter #(
        .bit_size (32),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .RegWrite   (RegWrite),
        .Write_addr (Write_addr),
        .Write_data (Write_data),
        .pending    (pending),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [36:0] exp_alu[$];
    logic [36:0] exp_ld[$];
    logic [4:0]  issue_log[$];
    int          ld_acc = 0;
    int          ld_stall_at = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Write port monitor and LD accept/stall tracking, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [36:0] got;
        logic [36:0] want;
        if (rst) begin
            if (ld_valid && ld_ready) begin
                ld_acc++;
            end else if (ld_valid && !ld_ready && ld_stall_at < 0) begin
                ld_stall_at = ld_acc;
            end
            if (RegWrite) begin
                got = {Write_addr, Write_data};
                issue_log.push_back(Write_addr);
                if (exp_ld.size() > 0 && exp_ld[0] == got) begin
                    want = exp_ld.pop_front();
                    check_eq("wb_ld", got, want);
                end else if (exp_alu.size() > 0 && exp_alu[0] == got) begin
                    want = exp_alu.pop_front();
                    check_eq("wb_alu", got, want);
                end else if (exp_ld.size() > 0) begin
                    want = exp_ld.pop_front();
                    check_eq("wb_ld_order", got, want);
                end else if (exp_alu.size() > 0) begin
                    want = exp_alu.pop_front();
                    check_eq("wb_alu_order", got, want);
                end else begin
                    check_eq("wb_unexpected", RegWrite, 1'b0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Callers start between a rising edge and the following falling edge.
    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
        @(negedge clk);
        while (!alu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("alu_push_timeout", alu_ready, 1'b1);
        @(posedge clk);
        if (a != 0) exp_alu.push_back({a, d});
        #1;
        alu_valid = 1'b0;
    endtask

    task automatic push_ld(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("ld_push_timeout", ld_ready, 1'b1);
        @(posedge clk);
        if (a != 0) exp_ld.push_back({a, d});
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        exp_alu.delete();
        exp_ld.delete();
        @(negedge clk);
        check_eq("rst_alu_ready", alu_ready, 1'b0);
        check_eq("rst_ld_ready", ld_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(idle && exp_alu.size() == 0 && exp_ld.size() == 0) && n < 200) begin
            step();
            n++;
        end
        check_eq("drain_idle", idle, 1'b1);
        check_eq("drain_left", exp_alu.size() + exp_ld.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("reset_regwrite", RegWrite, 1'b0);
        check_eq("reset_waddr", Write_addr, 5'd0);
        check_eq("reset_wdata", Write_data, 32'd0);
        check_eq("reset_pending", pending, 32'd0);
        check_eq("reset_idle", idle, 1'b1);
        check_eq("reset_ready", {alu_ready, ld_ready}, 2'b11);
        step();

        // Single write: exact cycle timing
        push_alu(5'd5, 32'h0000_00AA);
        @(negedge clk);
        check_eq("single_c1_pend", pending[5], 1'b1);
        check_eq("single_c1_we", RegWrite, 1'b0);
        @(negedge clk);
        check_eq("single_c2_we", RegWrite, 1'b1);
        check_eq("single_c2_addr", Write_addr, 5'd5);
        check_eq("single_c2_data", Write_data, 32'hAA);
        check_eq("single_c2_pend", pending[5], 1'b1);
        @(negedge clk);
        check_eq("single_c3_pend", pending, 32'd0);
        check_eq("single_c3_we", RegWrite, 1'b0);
        check_eq("single_c3_idle", idle, 1'b1);

        // Contention right after reset: LD first
        do_reset();
        issue_log.delete();
        fork
            push_alu(5'd3, 32'h11);
            push_ld(5'd4, 32'h22);
        join
        wait_drain();
        check_eq("cont_count", issue_log.size(), 2);
        if (issue_log.size() == 2) begin
            check_eq("cont_first", issue_log[0], 5'd4);
            check_eq("cont_second", issue_log[1], 5'd3);
        end

        // Back-pressure: an LD-only write leaves the pointer on LD, so ALU wins next
        do_reset();
        push_ld(5'd9, 32'h90);
        wait_drain();
        ld_acc = 0;
        ld_stall_at = -1;
        fork
            begin
                for (int i = 0; i < 4; i++) push_alu(5'(10 + i), 32'hA000 + i);
            end
            begin
                for (int i = 0; i < 3; i++) push_ld(5'(20 + i), 32'hB000 + i);
            end
        join
        wait_drain();
        check_eq("bp_ld_accepts", ld_acc, 3);
`ifndef WB_ARB_FIXED_PRIO_EN
        check_eq("bp_stall_after", ld_stall_at, 2);
`endif

        // Same-address race on r7
        fork
            push_alu(5'd7, 32'h77);
            push_ld(5'd7, 32'h88);
        join
        @(negedge clk);
        check_eq("race_c1_pend", pending[7], 1'b1);
        check_eq("race_c1_we", RegWrite, 1'b0);
        @(negedge clk);
        check_eq("race_c2_we", RegWrite, 1'b1);
        check_eq("race_c2_pend", pending[7], 1'b1);
        @(negedge clk);
        check_eq("race_c3_we", RegWrite, 1'b1);
        check_eq("race_c3_pend", pending[7], 1'b1);
        @(negedge clk);
        check_eq("race_c4_pend", pending, 32'd0);
        check_eq("race_c4_we", RegWrite, 1'b0);
        step();

        // Address zero: consumed silently, outputs hold
        push_alu(5'd0, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("zero_we", RegWrite, 1'b0);
            check_eq("zero_pend", pending, 32'd0);
            check_eq("zero_ready", alu_ready, 1'b1);
            check_eq("zero_hold_addr", Write_addr, 5'd7);
        end
        check_eq("zero_idle", idle, 1'b1);
        step();

        // Random mixed traffic
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    push_alu(5'($urandom_range(0, 31)), $urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    push_ld(5'($urandom_range(0, 31)), $urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
        join
        wait_drain();
        check_eq("rand_pending", pending, 32'd0);

        // Reset mid-operation with three writes in flight
        fork
            begin
                push_alu(5'd1, 32'h101);
                push_alu(5'd2, 32'h102);
            end
            push_ld(5'd3, 32'h103);
        join
        rst = 1'b0;
        exp_alu.delete();
        exp_ld.delete();
        @(negedge clk);
        check_eq("mid_rst_ready", {alu_ready, ld_ready}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("mid_we", RegWrite, 1'b0);
            check_eq("mid_pend", pending, 32'd0);
            check_eq("mid_idle", idle, 1'b1);
            check_eq("mid_ready", {alu_ready, ld_ready}, 2'b11);
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two requesters: the ALU result path and the load-data path. Each requester pushes (address, data) pairs through a valid/ready handshake into its own small FIFO. The arbiter drains one entry per cycle onto a registered write port that drives the register file's RegWrite/Write_addr/Write_data. It also exports a per-register pending-write scoreboard for the hazard-detection logic.

## Interface
- bit_size, 32, data width of every write.
- DEPTH, 2, entries per requester FIFO; power of two, ≥ 2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  5  ALU destination register.
- alu_data  in  bit_size  ALU write data.
- ld_valid / ld_ready / ld_addr / ld_data  same as ALU set, for the load path.
- RegWrite  out  1  write strobe to the register file.
- Write_addr  out  5  register file write address.
- Write_data  out  bit_size  register file write data.
- pending  out  32  bit i high while at least one write to register i is queued or being issued; bit 0 is always 0.
- idle  out  1  both FIFOs empty and RegWrite low.

## Operation
- **Accept**
  - A requester's entry is pushed on a rising edge where valid && ready.
  - ready = FIFO not full, driven only from registered state (no valid→ready path).
  - A full FIFO holds ready low even if it pops in the same cycle; there is no pass-through.
- **Grant**
  - Each cycle at most one FIFO head is popped.
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, round-robin applies: the requester not granted last wins.
  - The last-grant pointer updates on every grant.
  - After reset the pointer favours LD, so the first contended grant goes to LD.
- **Issue**
  - The popped entry loads the output register; RegWrite is high for exactly one cycle per nonzero-address pop.
  - A head with address 0 is popped and consumed, but RegWrite stays 0 that cycle.
  - When no write is issued, Write_addr and Write_data hold their last values.
- **Ordering**
  - Order within each requester is preserved.
  - Across requesters there is no ordering guarantee; the grant order decides the final value of a register written by both.
- **Scoreboard**
  - One counter per register, width clog2(2·DEPTH+1).
  - A counter increments on each accept to that address; two simultaneous accepts to the same address give +2.
  - A counter decrements on the edge where RegWrite is high for that address, so a counter may increment and decrement on the same edge.
  - pending[i] = counter != 0. Address 0 is never counted.
- **Reset (rst low at a rising edge)**
  - FIFOs emptied, counters cleared, pointer set to favour LD.
  - RegWrite = 0, Write_addr = 0, Write_data = 0, pending = 0, idle = 1.
  - alu_ready and ld_ready are forced 0 while rst is low.
  - Reset mid-operation discards all queued writes; nothing in flight is written afterwards.

## Timing
- An accept on edge N makes the entry eligible in cycle N+1. If granted, RegWrite is high in cycle N+2, and the register file captures the write on edge N+2→N+3.
- pending[i] rises in cycle N+1. It falls in the cycle after the final write edge, so a register read in that cycle already returns the new value.
- Throughput: 1 write per cycle sustained, shared across both requesters.
- A FIFO accepting every cycle while continuously granted never fills.

## Configuration
- WB_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; LD always wins contention and the round-robin pointer is removed.
  - Undefined: round-robin as described under Operation.

## Structure
- Package regfile_wb_pkg:
  - ADDR_W = 5 and NUM_REGS = 32.
  - Requester enum REQ_ALU / REQ_LD.
  - Write-entry struct {addr, data}.
- Sub-module wb_fifo: a DEPTH-entry synchronous FIFO with full/empty flags, instantiated once per requester.
- Arbitration, output register and scoreboard live in the top module.

## Test plan
- **Single write:** ALU pushes (addr 5, 0x0000_00AA) on edge 0 → RegWrite=1, Write_addr=5, Write_data=0xAA in cycle 2; pending[5] high in cycles 1–2, low from cycle 3.
- **Contention:** both requesters push on the same edge (ALU r3=0x11, LD r4=0x22) right after reset → LD's write issues first, ALU's next cycle; idle returns to 1 after the second write.
- **Back-pressure:** LD pushes 3 writes back-to-back while ALU keeps its FIFO non-empty, DEPTH=2 → ld_ready drops after 2 accepts and the third is held until a slot frees; all 3 writes issue in order.
- **Same-address race:** ALU and LD both push to r7 on one edge → pending[7] stays high until the second RegWrite, then clears; only one r7 counter path is exercised to 0.
- **Address zero:** ALU pushes (addr 0, 0xFFFF_FFFF) → entry consumed, RegWrite never asserts, pending[0]=0, ready stays 1.
- **Reset mid-operation:** with 3 entries queued, drive rst low for one edge → no RegWrite afterwards, pending=0, idle=1, both ready signals 0 during reset and 1 after.
